// File: rtl/tdc_pkg.sv
// tdc_pkg: FSM state encoding and default parameters for the TDC capture controller
package tdc_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, ENCODE, DONE} state_t;
    localparam int NTAPS_DEF   = 101;
    localparam int FW_DEF      = 7;
    localparam int CW_DEF      = 12;
    localparam int TIMEOUT_DEF = 4000;
endpackage

// File: rtl/tdc_therm_enc.sv
// tdc_therm_enc: highest tap index whose sum bit matches tap 0, else 0
module tdc_therm_enc import tdc_pkg::*; #(
    parameter int NTAPS = NTAPS_DEF,
    parameter int FW    = FW_DEF
) (
    input  logic [NTAPS-1:0] snap,
    output logic [FW-1:0]    fine
);
    always_comb begin
        fine = '0;
        for (int i = 1; i < NTAPS; i++)
            if (snap[i] == snap[0]) fine = FW'(i);
    end
endmodule

// File: rtl/tdc_capture_ctrl.sv
// tdc_capture_ctrl: arms a carry-chain TDC, captures coarse count and fine tap on hit or timeout
module tdc_capture_ctrl import tdc_pkg::*; #(
    parameter int NTAPS   = NTAPS_DEF,
    parameter int FW      = FW_DEF,
    parameter int CW      = CW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             hit,
    input  logic [NTAPS-1:0] tap_code,
    output logic             arm,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CW-1:0]    res_coarse,
    output logic [FW-1:0]    res_fine,
    output logic             res_timeout,
    output logic [7:0]       stray_cnt
);
    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [NTAPS-1:0] snap;
    logic [FW-1:0]    fine;
    logic             tmo;

    assign tmo = cnt == CW'(TIMEOUT - 1);

    tdc_therm_enc #(.NTAPS(NTAPS), .FW(FW)) u_enc (.snap(snap), .fine(fine));

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? ARMED : IDLE;
            ARMED:   state_nxt = hit ? ENCODE : tmo ? DONE : ARMED;
            ENCODE:  state_nxt = DONE;
            DONE:    state_nxt = res_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
        arm       = state == ARMED;
        busy      = state != IDLE;
        res_valid = state == DONE;
    end

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) cnt <= '0;
        else if (state == IDLE && start) cnt <= '0;
        else if (state == ARMED && !hit) cnt <= cnt + 1'b1;

    // Results are only written in ARMED/ENCODE, so they stay frozen throughout DONE.
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            snap        <= '0;
            res_coarse  <= '0;
            res_fine    <= '0;
            res_timeout <= 1'b0;
        end else if (state == ARMED && hit) begin
            snap        <= tap_code;
            res_coarse  <= cnt;
            res_timeout <= 1'b0;
        end else if (state == ARMED && tmo) begin
            res_coarse  <= CW'(TIMEOUT);
            res_fine    <= '0;
            res_timeout <= 1'b1;
        end else if (state == ENCODE) begin
            res_fine    <= fine;
        end

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) stray_cnt <= '0;
        else if (hit && state != ARMED && stray_cnt != 8'hFF) stray_cnt <= stray_cnt + 1'b1;
endmodule

// File: tb/tb_tdc_capture_ctrl.sv
// tb_tdc_capture_ctrl: randomized directed bench against a behavioural TDC model
module tb_tdc_capture_ctrl;
    localparam int NT = 101;
    localparam int FW = 7;
    localparam int CW = 12;
    localparam int TO = 16;

    logic          CLK, RST_N, start, hit, res_ready;
    logic [NT-1:0] tap_code;
    logic          arm, busy, res_valid, res_timeout;
    logic [CW-1:0] res_coarse;
    logic [FW-1:0] res_fine;
    logic [7:0]    stray_cnt;
    int            checks, failures, exp_stray;

    tdc_capture_ctrl #(.NTAPS(NT), .FW(FW), .CW(CW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .hit(hit), .tap_code(tap_code),
        .arm(arm), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_coarse(res_coarse), .res_fine(res_fine), .res_timeout(res_timeout),
        .stray_cnt(stray_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int ref_fine(input logic [NT-1:0] tc);
        for (int i = NT - 1; i >= 1; i--)
            if (tc[i] == tc[0]) return i;
        return 0;
    endfunction

    function automatic logic [NT-1:0] rand_code();
        logic [NT-1:0] v = '0;
        int n = $urandom_range(0, NT);
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        if ($urandom_range(0, 1) == 1) v = ~v;
        if ($urandom_range(0, 3) == 0)
            for (int i = 0; i < NT; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    function automatic void stray_inc();
        if (exp_stray < 255) exp_stray++;
    endfunction

    task automatic stray_hit();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        stray_inc();
    endtask

    task automatic chk_result(input string tag, input int c, input int f, input int t);
        chk({tag, "_valid"}, res_valid, 1);
        chk({tag, "_coarse"}, res_coarse, c);
        chk({tag, "_fine"}, res_fine, f);
        chk({tag, "_timeout"}, res_timeout, t);
    endtask

    // k idle ARMED cycles then a hit; k >= TO means no hit is ever given
    task automatic measure(input int k, input logic [NT-1:0] tc, input int hold, input bit co);
        int ec, ef, et;
        start = 1'b1;
        hit = co;
        if (co) stray_inc();
        tick();
        start = 1'b0;
        hit = 1'b0;
        chk("armed_arm", arm, 1);
        chk("armed_busy", busy, 1);
        if (k < TO) begin
            repeat (k) begin
                tap_code = rand_code();
                tick();
            end
            hit = 1'b1;
            tap_code = tc;
            tick();
            hit = 1'b0;
            tap_code = rand_code();
            chk("encode_novalid", res_valid, 0);
            chk("encode_noarm", arm, 0);
            tick();
            ec = k; ef = ref_fine(tc); et = 0;
        end else begin
            repeat (TO - 1) tick();
            chk("pre_timeout_novalid", res_valid, 0);
            tick();
            ec = TO; ef = 0; et = 1;
        end
        chk_result("done", ec, ef, et);
        repeat (hold) begin
            tap_code = rand_code();
            start = 1'($urandom_range(0, 1));
            hit = 1'($urandom_range(0, 1));
            if (hit) stray_inc();
            tick();
            start = 1'b0;
            hit = 1'b0;
            chk_result("hold", ec, ef, et);
            chk("hold_arm", arm, 0);
        end
        res_ready = 1'b1;
        start = 1'b1;
        tick();
        res_ready = 1'b0;
        start = 1'b0;
        chk("ack_valid", res_valid, 0);
        chk("ack_busy", busy, 0);
        chk("stray", stray_cnt, exp_stray);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_arm"}, arm, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, res_valid, 0);
        chk({tag, "_timeout"}, res_timeout, 0);
        chk({tag, "_coarse"}, res_coarse, 0);
        chk({tag, "_fine"}, res_fine, 0);
        chk({tag, "_stray"}, stray_cnt, 0);
    endtask

    task automatic reset_in(input bit in_done);
        stray_hit();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (in_done ? TO + 2 : 3) tick();
        chk("pre_reset_busy", busy, 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk_reset(in_done ? "rst_done" : "rst_armed");
        exp_stray = 0;
        tick();
        RST_N = 1'b1;
        repeat (TO + 4) begin
            tick();
            chk("post_reset_valid", res_valid, 0);
            chk("post_reset_busy", busy, 0);
        end
    endtask

    initial begin
        logic [NT-1:0] v;
        checks = 0;
        failures = 0;
        exp_stray = 0;
        RST_N = 1'b0;
        start = 1'b0;
        hit = 1'b0;
        res_ready = 1'b0;
        tap_code = '0;
        #1;
        chk_reset("reset");
        repeat (3) tick();
        chk_reset("reset_held");
        RST_N = 1'b1;

        v = '0;
        for (int i = 0; i < 38; i++) v[i] = 1'b1;
        measure(5, v, 0, 0);
        measure(TO, rand_code(), 0, 0);
        measure(3, rand_code(), 10, 0);
        measure(4, rand_code(), 1, 1);

        repeat (300) stray_hit();
        chk("stray_sat", stray_cnt, 255);
        measure(7, rand_code(), 2, 0);
        chk("stray_sat_hold", stray_cnt, 255);

        measure(TO - 1, '1, 0, 0);
        measure(TO - 1, '0, 0, 0);
        measure(0, rand_code(), 0, 0);

        reset_in(0);
        measure(2, rand_code(), 0, 0);
        reset_in(1);
        measure(TO, rand_code(), 0, 0);

        repeat (40) begin
            repeat ($urandom_range(0, 2)) stray_hit();
            measure($urandom_range(0, TO + 2), rand_code(), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
